uart_io_16: RTL and testbench

//   Memory-mapped 8N1 UART peripheral on the system16 CPU bus, decoded at 0x4000-0x40ff.
//   Its registered dout joins the top-level cpu_din select as a fifth source.
//   TX and RX paths each have an 8-entry FIFO so the CPU can issue bursts of bytes.
//   A programmable baud divisor sets the bit rate for both paths.

---
 rtl/uart_io_16.sv | 169 ++++++++++++++++
 tb/tb_uart_io_16.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_16.sv
// Memory-mapped 8N1 UART with 8-entry TX/RX FIFOs and a programmable baud divisor.
// Register window decoded on addr[15:8]; dout is registered with one cycle of read latency.
module uart_io_16 #(
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter int unsigned FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        we,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_ready
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic       sel;
  logic [7:0] off;
  logic       wr_tx, wr_rxctl, wr_div;
  assign sel      = (addr[15:8] == BASE_ADDR[15:8]);
  assign off      = addr[7:0];
  assign wr_tx    = we && sel && (off == 8'h01);
  assign wr_rxctl = we && sel && (off == 8'h03);
  assign wr_div   = we && sel && (off == 8'h04);

  logic [15:0] baud;

  // TX path
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp;
  logic [FIFO_AW:0]   tx_cnt;
  logic [1:0]         tx_state;
  logic [15:0]        tx_div, tx_bcnt;
  logic [2:0]         tx_bit;
  logic [7:0]         tx_sh;
  logic               tx_full, tx_empty, tx_push, tx_pop, tx_tick, txd_q;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_tx && !tx_full;
  assign tx_tick  = (tx_bcnt == tx_div);
  assign tx_pop   = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));
  assign txd      = txd_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= din[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      tx_state <= S_IDLE; tx_div <= DEFAULT_DIV; tx_bcnt <= '0;
      tx_bit <= '0; tx_sh <= '0; txd_q <= 1'b1;
    end else begin
      // txd follows the state one clock later, so the start bit begins 1 clk after the pop
      txd_q <= (tx_state == S_START) ? 1'b0 : (tx_state == S_DATA) ? tx_sh[0] : 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop) tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_sh <= tx_mem[tx_rp]; tx_div <= baud; tx_bcnt <= '0; tx_state <= S_START;
        end
        S_START: if (tx_tick) begin
          tx_bcnt <= '0; tx_bit <= '0; tx_state <= S_DATA;
        end else tx_bcnt <= tx_bcnt + 1'b1;
        S_DATA: if (tx_tick) begin
          tx_bcnt <= '0; tx_sh <= tx_sh >> 1; tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_state <= S_STOP;
        end else tx_bcnt <= tx_bcnt + 1'b1;
        default: if (tx_tick) begin
          tx_bcnt <= '0;
          if (tx_pop) begin
            tx_sh <= tx_mem[tx_rp]; tx_div <= baud; tx_state <= S_START;
          end else tx_state <= S_IDLE;
        end else tx_bcnt <= tx_bcnt + 1'b1;
      endcase
    end
  end

  // RX path
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp, rx_rp;
  logic [FIFO_AW:0]   rx_cnt;
  logic [1:0]         rx_state;
  logic [15:0]        rx_div, rx_bcnt;
  logic [16:0]        rx_half;
  logic [2:0]         rx_bit;
  logic [7:0]         rx_sh;
  logic               s1, s2, s2_prev;
  logic               rx_full, rx_empty, rx_tick, rx_done, rx_push, rx_pop;
  logic               set_ovr, set_frm, flag_clr, overrun, frm_err;

  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_tick  = (rx_bcnt == rx_div);
  assign rx_half  = ({1'b0, rx_div} + 17'd1) >> 1;
  assign rx_done  = (rx_state == S_STOP) && rx_tick;
  assign rx_push  = rx_done && s2 && !rx_full;
  assign set_ovr  = rx_done && s2 && rx_full;
  assign set_frm  = rx_done && !s2;
  assign rx_pop   = wr_rxctl && din[0] && !rx_empty;
  assign flag_clr = wr_rxctl && din[15];
  assign rx_ready = !rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1; s2 <= 1'b1; s2_prev <= 1'b1;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      rx_state <= S_IDLE; rx_div <= DEFAULT_DIV; rx_bcnt <= '0;
      rx_bit <= '0; rx_sh <= '0; overrun <= 1'b0; frm_err <= 1'b0;
    end else begin
      s1 <= rxd; s2 <= s1; s2_prev <= s2;
      overrun <= set_ovr || (overrun && !flag_clr);
      frm_err <= set_frm || (frm_err && !flag_clr);
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop) rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
      case (rx_state)
        // the detection cycle counts as the first clock of the start bit
        S_IDLE: if (s2_prev && !s2) begin
          rx_state <= S_START; rx_bcnt <= 16'd1; rx_div <= baud;
        end
        S_START: if ({1'b0, rx_bcnt} == rx_half) begin
          rx_bcnt <= '0; rx_bit <= '0;
          rx_state <= s2 ? S_IDLE : S_DATA;
        end else rx_bcnt <= rx_bcnt + 1'b1;
        S_DATA: if (rx_tick) begin
          rx_bcnt <= '0; rx_sh <= {s2, rx_sh[7:1]}; rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= S_STOP;
        end else rx_bcnt <= rx_bcnt + 1'b1;
        default: if (rx_tick) begin
          rx_bcnt <= '0; rx_state <= S_IDLE;
        end else rx_bcnt <= rx_bcnt + 1'b1;
      endcase
    end
  end

  // Divisor register and registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud <= DEFAULT_DIV;
      dout <= '0;
    end else begin
      if (wr_div) baud <= (din < 16'd3) ? 16'd3 : din;
      if (!sel) dout <= '0;
      else begin
        case (off)
          8'h00: dout <= {10'b0, frm_err, overrun, rx_full, !rx_empty,
                          tx_full, (tx_state != S_IDLE) || !tx_empty};
          8'h02: dout <= rx_empty ? 16'h0000 : {8'h00, rx_mem[rx_rp]};
          8'h04: dout <= baud;
          default: dout <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_io_16.sv
// Directed-sequence bench for uart_io_16 with random payloads checked against queue models.
module tb_uart_io_16;
  logic        clk = 1'b0, reset_n, we, rxd, txd, rx_ready;
  logic [15:0] addr, din, dout;
  int          checks = 0, errors = 0, cyc = 0;

  localparam logic [15:0] A_STAT = 16'h4000, A_TX = 16'h4001, A_RX = 16'h4002;
  localparam logic [15:0] A_CTL = 16'h4003, A_DIV = 16'h4004;

  uart_io_16 dut (.clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
                  .we(we), .rxd(rxd), .txd(txd), .rx_ready(rx_ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); addr = a; din = d; we = 1'b1;
    @(negedge clk); we = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk); addr = a; we = 1'b0;
    @(posedge clk); #1 d = dout;
  endtask

  // Serialise one 8N1 frame on rxd, p clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stopb, input int p);
    @(negedge clk);
    rxd = 1'b0; repeat (p) @(negedge clk);
    for (int k = 0; k < 8; k++) begin rxd = b[k]; repeat (p) @(negedge clk); end
    rxd = stopb; repeat (p) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Decode one frame from txd by mid-bit sampling; t0 is the cycle of the start bit
  task automatic get_tx(input int p, output logic [7:0] b, output logic stopb,
                        output int t0, output logic ok);
    int n = 0;
    b = 8'h00; stopb = 1'b0;
    while (txd !== 1'b0 && n < 20000) begin step(); n++; end
    ok = (txd === 1'b0);
    t0 = cyc;
    if (!ok) return;
    repeat (p / 2) step();
    for (int k = 0; k < 8; k++) begin repeat (p) step(); b[k] = txd; end
    repeat (p) step();
    stopb = txd;
  endtask

  logic [15:0] r;
  logic [7:0]  bt, got, tx_b [10], exp_b;
  logic [9:0]  frame;
  logic        sb, ok, ovr, idle_ok;
  logic [7:0]  rxq [$];
  int          t, tprev, lat, dv;

  initial begin
    reset_n = 1'b0; we = 1'b0; addr = 16'h0000; din = 16'h0000; rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", {15'b0, txd}, 16'h0001);
    chk("rst_dout", dout, 16'h0000);
    chk("rst_rx_ready", {15'b0, rx_ready}, 16'h0000);
    reset_n = 1'b1;

    // Reset in the middle of a TX frame with a byte waiting in the RX FIFO
    wr(A_DIV, 16'd3);
    send_rx(8'($urandom), 1'b1, 4);
    repeat (10) @(negedge clk);
    chk("pre_rst_rx_ready", {15'b0, rx_ready}, 16'h0001);
    wr(A_TX, 16'($urandom_range(0, 255)));
    wr(A_TX, 16'h00F0);
    repeat (2) @(negedge clk);
    chk("pre_rst_txd_start", {15'b0, txd}, 16'h0000);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_txd", {15'b0, txd}, 16'h0001);
    chk("midrst_dout", dout, 16'h0000);
    chk("midrst_rx_ready", {15'b0, rx_ready}, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(A_STAT, r); chk("rst_status", r, 16'h0000);
    rd(A_DIV, r);  chk("rst_bauddiv", r, 16'd867);
    idle_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); if (txd !== 1'b1) idle_ok = 1'b0; end
    chk("rst_tx_aborted", {15'b0, idle_ok}, 16'h0001);

    // TX cycle-exact timing: 0x55 at 4 clk/bit, start bit 2 clk after the write edge
    wr(A_DIV, 16'd3);
    @(negedge clk); addr = A_TX; din = 16'h0055; we = 1'b1;
    @(posedge clk); #1 we = 1'b0; addr = 16'h0000;
    lat = 0;
    while (txd !== 1'b0 && lat < 20) begin step(); lat++; end
    chk("tx_start_latency", 16'(lat), 16'd2);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("tx55_cyc%0d", k), {15'b0, txd}, {15'b0, frame[k / 4]});
      step();
    end
    rd(A_STAT, r); chk("tx55_status_idle", r, 16'h0000);

    // TX burst: one byte goes straight to the shifter, 8 fill the FIFO, the 10th is dropped
    for (int i = 0; i < 10; i++) tx_b[i] = 8'($urandom);
    fork
      begin
        @(negedge clk); addr = A_TX; we = 1'b1;
        for (int i = 0; i < 10; i++) begin din = {8'h00, tx_b[i]}; @(negedge clk); end
        we = 1'b0; addr = 16'h0000;
        rd(A_STAT, r); chk("txburst_status_full", r, 16'h0003);
      end
      begin
        tprev = 0;
        for (int i = 0; i < 9; i++) begin
          get_tx(4, got, sb, t, ok);
          chk($sformatf("txburst_found%0d", i), {15'b0, ok}, 16'h0001);
          chk($sformatf("txburst_byte%0d", i), {8'h00, got}, {8'h00, tx_b[i]});
          chk($sformatf("txburst_stop%0d", i), {15'b0, sb}, 16'h0001);
          if (i > 0) chk($sformatf("txburst_gap%0d", i), 16'(t - tprev), 16'd40);
          tprev = t;
        end
      end
    join
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin step(); if (txd !== 1'b1) idle_ok = 1'b0; end
    chk("txburst_tenth_dropped", {15'b0, idle_ok}, 16'h0001);
    rd(A_STAT, r); chk("txburst_status_end", r, 16'h0000);

    // RX: 9 back-to-back frames into an 8-entry FIFO
    wr(A_DIV, 16'd7);
    rxq.delete(); ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bt = 8'($urandom);
      send_rx(bt, 1'b1, 8);
      if (rxq.size() < 8) rxq.push_back(bt); else ovr = 1'b1;
    end
    repeat (20) @(negedge clk);
    rd(A_STAT, r);
    chk("rx_status_full", r, {11'b0, ovr, rxq.size() == 8, rxq.size() != 0, 2'b00});
    chk("rx_ready_full", {15'b0, rx_ready}, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      rd(A_RX, r); chk($sformatf("rx_pop%0d", i), r, {8'h00, rxq[0]});
      wr(A_CTL, 16'h0001);
      void'(rxq.pop_front());
    end
    chk("rx_ready_empty", {15'b0, rx_ready}, 16'h0000);
    rd(A_RX, r);   chk("rx_empty_read", r, 16'h0000);
    wr(A_CTL, 16'h0001);
    rd(A_STAT, r); chk("rx_status_sticky_ovr", r, 16'h0010);
    wr(A_CTL, 16'h8000);
    rd(A_STAT, r); chk("rx_status_cleared", r, 16'h0000);

    // RX faults: short glitch, then a frame with a low stop bit
    @(negedge clk); rxd = 1'b0;
    repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (40) @(negedge clk);
    rd(A_STAT, r); chk("glitch_status", r, 16'h0000);
    send_rx(8'($urandom), 1'b0, 8);
    repeat (20) @(negedge clk);
    rd(A_STAT, r); chk("frmerr_status", r, 16'h0020);
    chk("frmerr_no_push", {15'b0, rx_ready}, 16'h0000);
    wr(A_CTL, 16'h8000);
    rd(A_STAT, r); chk("frmerr_cleared", r, 16'h0000);

    // Random divisors: one TX and one RX byte each
    for (int it = 0; it < 4; it++) begin
      dv = $urandom_range(3, 20);
      wr(A_DIV, 16'(dv));
      exp_b = 8'($urandom);
      wr(A_TX, {8'h00, exp_b});
      get_tx(dv + 1, got, sb, t, ok);
      chk($sformatf("rnd_tx_byte%0d", it), {7'b0, sb, got}, {8'h01, exp_b});
      repeat (2 * dv) @(negedge clk);
      exp_b = 8'($urandom);
      send_rx(exp_b, 1'b1, dv + 1);
      repeat (3 * dv) @(negedge clk);
      rd(A_RX, r); chk($sformatf("rnd_rx_byte%0d", it), r, {8'h00, exp_b});
      wr(A_CTL, 16'h0001);
    end
    rd(A_STAT, r); chk("rnd_status_end", r, 16'h0000);

    // Boundaries: divisor clamp, unmapped offset, out-of-window accesses
    wr(A_DIV, 16'd1);
    rd(A_DIV, r);     chk("div_clamp", r, 16'd3);
    rd(16'h4010, r);  chk("unmapped_read", r, 16'h0000);
    rd(16'h5004, r);  chk("outside_read", r, 16'h0000);
    wr(16'h5001, 16'h00AA);
    repeat (3) @(negedge clk);
    rd(A_STAT, r);    chk("outside_write_ignored", r, 16'h0000);

    // BAUDDIV change mid-frame applies to the following frame only
    tx_b[0] = 8'($urandom); tx_b[1] = 8'($urandom);
    wr(A_DIV, 16'd3);
    wr(A_TX, {8'h00, tx_b[0]});
    wr(A_TX, {8'h00, tx_b[1]});
    fork
      get_tx(4, got, sb, tprev, ok);
      begin repeat (10) @(negedge clk); wr(A_DIV, 16'd15); end
    join
    chk("middiv_f1", {6'b0, ok, sb, got}, {8'h03, tx_b[0]});
    get_tx(16, got, sb, t, ok);
    chk("middiv_f2", {6'b0, ok, sb, got}, {8'h03, tx_b[1]});
    chk("middiv_gap", 16'(t - tprev), 16'd40);
    rd(A_DIV, r);     chk("middiv_readback", r, 16'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
